rv_mem_access: RTL

- Memory-access stage directly downstream of the execute/ALU stage.
- Consumes per-instruction result, effective address, store data, byte-select and funct3, and performs the data-bus load/store transaction with a req/ack handshake.
- Aligns and sign/zero-extends load data, and presents a registered writeback packet to the register-file write stage.
- Stalls upstream while a bus access is outstanding; detects misaligned accesses and bus timeouts.

---
 rtl/rv_mem_access.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/rv_mem_access.sv
// Memory-access stage: captures the execute result into a slot, runs the data-bus
// req/ack transaction, aligns load data and registers the writeback packet.
module rv_mem_access #(
  parameter int DADDR_BITS     = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_flush,
  input  logic [31:0]           i_result,
  input  logic [31:0]           i_add,
  input  logic                  i_load,
  input  logic                  i_store,
  input  logic                  i_reg_write,
  input  logic [4:0]            i_rd,
  input  logic [2:0]            i_funct3,
  input  logic [31:0]           i_wdata,
  input  logic [3:0]            i_wsel,
  input  logic                  i_to_trap,
  output logic                  o_stall,
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic [DADDR_BITS-1:0] o_dmem_addr,
  output logic [3:0]            o_dmem_wsel,
  output logic [31:0]           o_dmem_wdata,
  input  logic                  i_dmem_ack,
  input  logic [31:0]           i_dmem_rdata,
  output logic                  o_wb_valid,
  output logic                  o_wb_reg_write,
  output logic [4:0]            o_wb_rd,
  output logic [31:0]           o_wb_data,
  output logic                  o_wb_trap,
  output logic [1:0]            o_wb_fault
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_e;

  typedef struct packed {
    logic        valid;
    logic        load;
    logic        store;
    logic        reg_write;
    logic        to_trap;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [3:0]  wsel;
    logic [31:0] result;
    logic [31:0] add;
    logic [31:0] wdata;
  } slot_t;

  localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

  function automatic logic [31:0] align_load(input logic [31:0] rdata,
                                             input logic [1:0]  off,
                                             input logic [2:0]  f3);
    logic [31:0] sh_b;
    logic [31:0] sh_h;
    sh_b = rdata >> {off, 3'b000};
    sh_h = rdata >> {off[1], 4'b0000};
    case (f3[1:0])
      2'b00:   align_load = f3[2] ? {24'h000000, sh_b[7:0]} : {{24{sh_b[7]}}, sh_b[7:0]};
      2'b01:   align_load = f3[2] ? {16'h0000, sh_h[15:0]} : {{16{sh_h[15]}}, sh_h[15:0]};
      default: align_load = rdata;
    endcase
  endfunction

  slot_t       slot_q, slot_d;
  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;

  logic        wb_valid_q, wb_valid_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_trap_q, wb_trap_d;
  logic [1:0]  wb_fault_q, wb_fault_d;

  logic        is_mem_s;
  logic        misalign_s;
  logic        mem_go_s;
  logic        req_s;
  logic        stall_s;
  logic        timeout_s;
  logic        trap_s;

  // Misalignment and bus-start decode on the resident slot.
  always_comb begin
    is_mem_s   = slot_q.valid & (slot_q.load | slot_q.store);
    misalign_s = 1'b0;
    case (slot_q.funct3[1:0])
      2'b01:   misalign_s = is_mem_s & slot_q.add[0];
      2'b10:   misalign_s = is_mem_s & (slot_q.add[1:0] != 2'b00);
      default: misalign_s = 1'b0;
    endcase
    mem_go_s = is_mem_s & ~misalign_s & ~slot_q.to_trap;
  end

  // Request FSM; a freshly filled slot requests in the same cycle it lands.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_s     = 1'b0;
    timeout_s = 1'b0;
    stall_s   = 1'b0;
    case (state_q)
      S_IDLE:  req_s = mem_go_s;
      S_REQ:   req_s = 1'b1;
      default: req_s = 1'b0;
    endcase
    timeout_s = TO_EN & req_s & ~i_dmem_ack & (cnt_q == TO_LAST);
    stall_s   = req_s & ~i_dmem_ack & ~timeout_s;
    if (stall_s) begin
      state_d = S_REQ;
      cnt_d   = TO_EN ? (cnt_q + 32'd1) : cnt_q;
    end else begin
      state_d = S_IDLE;
      cnt_d   = 32'd0;
    end
  end

  // Slot capture: hold while stalled, bubble on flush, otherwise take the inputs.
  always_comb begin
    slot_d = slot_q;
    if (stall_s) begin
      slot_d = slot_q;
    end else if (i_flush) begin
      slot_d = '0;
    end else begin
      slot_d.valid     = 1'b1;
      slot_d.load      = i_load;
      slot_d.store     = i_store;
      slot_d.reg_write = i_reg_write;
      slot_d.to_trap   = i_to_trap;
      slot_d.rd        = i_rd;
      slot_d.funct3    = i_funct3;
      slot_d.wsel      = i_wsel;
      slot_d.result    = i_result;
      slot_d.add       = i_add;
      slot_d.wdata     = i_wdata;
    end
  end

  // Writeback packet; produced whenever the slot's instruction retires this cycle.
  always_comb begin
    wb_valid_d     = slot_q.valid & ~stall_s;
    trap_s         = slot_q.to_trap | misalign_s | timeout_s;
    wb_reg_write_d = 1'b0;
    wb_rd_d        = 5'd0;
    wb_data_d      = 32'h0000_0000;
    wb_trap_d      = 1'b0;
    wb_fault_d     = 2'b00;
    if (wb_valid_d) begin
      wb_reg_write_d = slot_q.reg_write & ~slot_q.store & ~trap_s;
      wb_rd_d        = slot_q.rd;
      wb_data_d      = slot_q.load ? align_load(i_dmem_rdata, slot_q.add[1:0], slot_q.funct3)
                                   : slot_q.result;
      wb_trap_d      = trap_s;
      if (misalign_s) begin
        wb_fault_d = 2'b01;
      end else if (timeout_s) begin
        wb_fault_d = 2'b10;
      end else begin
        wb_fault_d = 2'b00;
      end
    end else begin
      wb_reg_write_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      slot_q         <= '0;
      state_q        <= S_IDLE;
      cnt_q          <= 32'd0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_data_q      <= 32'h0000_0000;
      wb_trap_q      <= 1'b0;
      wb_fault_q     <= 2'b00;
    end else begin
      slot_q         <= slot_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      wb_trap_q      <= wb_trap_d;
      wb_fault_q     <= wb_fault_d;
    end
  end

  // Bus fields are gated by req so an idle bus reads all zeros.
  assign o_stall      = stall_s;
  assign o_dmem_req   = req_s;
  assign o_dmem_we    = req_s & slot_q.store;
  assign o_dmem_addr  = req_s ? {slot_q.add[DADDR_BITS-1:2], 2'b00} : {DADDR_BITS{1'b0}};
  assign o_dmem_wsel  = req_s ? (slot_q.store ? slot_q.wsel : 4'b1111) : 4'b0000;
  assign o_dmem_wdata = (req_s & slot_q.store) ? slot_q.wdata : 32'h0000_0000;

  assign o_wb_valid     = wb_valid_q;
  assign o_wb_reg_write = wb_reg_write_q;
  assign o_wb_rd        = wb_rd_q;
  assign o_wb_data      = wb_data_q;
  assign o_wb_trap      = wb_trap_q;
  assign o_wb_fault     = wb_fault_q;

endmodule
